md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multicycle multiply/divide unit and HI/LO owner for the MiniSys-1A pipeline, sitting beside the ALU in EX.
//  - Accepts mult/multu/div/divu from the control-unit decode (md, alu_md) and runs them on one shared
//    iterative shift-add / restoring-divide datapath.
//  - Serves mthi/mtlo/mfhi/mflo and raises a pipeline stall while the result is pending.
// PARAMETERS
//  WIDTH    32  operand width; HI and LO are WIDTH bits each
//  CNT_W    5   iteration counter width, clog2(WIDTH)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  md_start   in   1      EX holds mult/multu/div/divu (control-unit md)
//  alu_md     in   2      00 mult, 01 multu, 10 div, 11 divu
//  src_a      in   WIDTH  rs operand (multiplicand / dividend)
//  src_b      in   WIDTH  rt operand (multiplier / divisor)
//  op_mthi    in   1      EX holds mthi; src_a -> HI
//  op_mtlo    in   1      EX holds mtlo; src_a -> LO
//  op_mfhi    in   1      EX holds mfhi
//  op_mflo    in   1      EX holds mflo
//  cancel     in   1      EX flush; abort the operation in flight
//  busy       out  1      operation in flight (registered)
//  stall      out  1      freeze IF..EX this cycle (combinational)
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
//  done       out  1      1-cycle pulse: HI/LO just updated by an operation
//  div_zero   out  1      1-cycle pulse: div/divu with src_b == 0 accepted
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; count and work registers cleared.
//  FSM IDLE -> CALC -> FIXUP -> IDLE.
//   IDLE:  md_start=1 and cancel=0:
//          - capture op, |src_a| and |src_b| (signed ops) or raw operands, and result signs
//          - count=0, go to CALC
//          Divisor 0: stay IDLE, pulse div_zero next cycle, HI/LO unchanged.
//   CALC:  one radix-2 step per cycle, count 0..WIDTH-1.
//          - mult: add-and-shift into a 2*WIDTH accumulator
//          - div: restoring shift-subtract
//          Go to FIXUP after count==WIDTH-1.
//   FIXUP: negate product if operand signs differ (mult). div: negate quotient if signs differ,
//          remainder takes the dividend's sign.
//          - mult: HI:LO <= product
//          - div: LO <= quotient, HI <= remainder
//          Pulse done; go to IDLE.
//  Latency: start accepted at edge E0; busy=1 from E0 through E(WIDTH+1); HI/LO and done appear at E(WIDTH+1),
//   i.e. 33 cycles for WIDTH=32. At most one operation in flight.
//  stall = busy & (md_start | op_mthi | op_mtlo | op_mfhi | op_mflo). Unrelated instructions flow freely.
//  md_start while busy: not accepted; it is stalled and re-seen in IDLE the cycle after done.
//  mthi/mtlo in IDLE: HI/LO written at the next edge.
//   - If md_start is also high, md_start wins and the move is ignored.
//   - mthi and mtlo together write both.
//  mfhi/mflo: hi/lo are read directly. An op completing at edge E is visible to mfhi/mflo in cycle E+1.
//  cancel: IDLE ignores start. CALC/FIXUP -> IDLE at the next edge; HI/LO unchanged, no done, busy drops.
//  Mid-operation reset: immediate IDLE, all outputs to reset values.
//  Signed div MIN/-1: LO=0x80000000, HI=0, no flag. Unsigned ops never negate.
// STRUCTURE
//  Package md_pkg:
//   - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU (2-bit)
//   - state encodings S_IDLE/S_CALC/S_FIXUP
//   - WIDTH default
//  Sub-module md_iter_core: holds the accumulator/remainder, quotient and count registers.
//   - Does one mult or div step per `step` strobe.
//   - Exposes raw magnitude results; sign fixup and HI/LO stay in md_sequencer.
// TESTING
//  1 mult 0xFFFFFFFF x 0x00000002 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, done pulses once.
//  2 multu 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
//  3 div -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu 7 / 0 -> div_zero pulse, busy stays 0,
//    HI/LO unchanged.
//  4 mflo issued 1 cycle after mult start -> stall=1 for 32 cycles, then mflo reads the new LO.
//    An independent add in the shadow -> stall=0.
//  5 mthi 0x12345678 in IDLE -> hi=0x12345678 next cycle.
//    Reset asserted at CALC count 10 -> busy=0, hi=lo=0 immediately, no done.
//  6 cancel during CALC -> IDLE next edge, HI/LO keep prior values.
//    Back-to-back mult held in EX -> accepted the cycle after the first done.

Source files
------------

// File: rtl/md_pkg.sv
// Shared opcodes, FSM encodings and width default for the multiply/divide unit.
package md_pkg;
    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_FIXUP = 2'b10
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return ~op[0];
    endfunction
endpackage

// File: rtl/md_iter_core.sv
// Shared radix-2 iteration engine: shift-add multiply or restoring divide on magnitudes.
module md_iter_core
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_step,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);
    // Mult: acc = {partial, multiplier}; div: acc = {remainder, quotient/dividend}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opd;
    logic               r_div;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_next;

    always_comb begin
        w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
        w_shl  = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff = w_shl - {1'b0, r_opd};
        if (!r_div)
            w_next = {w_sum, r_acc[WIDTH-1:1]};
        else if (w_diff[WIDTH])
            w_next = {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        else
            w_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_opd <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_acc <= {{WIDTH{1'b0}}, (i_div ? i_a : i_b)};
            r_opd <= i_div ? i_b : i_a;
            r_div <= i_div;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= w_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == CNT_W'(WIDTH-1));
endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner and multicycle mult/div sequencer for EX; stalls dependents while busy.
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [1:0]       alu_md,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             op_mthi,
    input  logic             op_mtlo,
    input  logic             op_mfhi,
    input  logic             op_mflo,
    input  logic             cancel,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_zero
);
    md_state_e r_state;
    logic      r_div;
    logic      r_neg_res;
    logic      r_neg_rem;

    md_op_e             w_op;
    logic               w_signed;
    logic               w_is_div;
    logic               w_dz;
    logic               w_accept;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_op     = md_op_e'(alu_md);
    assign w_signed = md_is_signed(w_op);
    assign w_is_div = md_is_div(w_op);
    assign w_dz     = w_is_div && (src_b == '0);
    assign w_accept = (r_state == S_IDLE) && md_start && !cancel && !w_dz;
    assign w_a_mag  = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_b_mag  = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    assign stall = busy & (md_start | op_mthi | op_mtlo | op_mfhi | op_mflo);

    md_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_div  (w_is_div),
        .i_a    (w_a_mag),
        .i_b    (w_b_mag),
        .i_step ((r_state == S_CALC) && !cancel),
        .o_acc  (w_acc),
        .o_last (w_last)
    );

    // Remainder follows the dividend's sign; quotient/product follow the xor of signs.
    assign w_prod = r_neg_res ? -w_acc : w_acc;
    assign w_quo  = r_neg_res ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (md_start && !cancel) begin
                        if (w_dz) begin
                            div_zero <= 1'b1;
                        end else begin
                            r_state   <= S_CALC;
                            busy      <= 1'b1;
                            r_div     <= w_is_div;
                            r_neg_res <= w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            r_neg_rem <= w_signed && w_is_div && src_a[WIDTH-1];
                        end
                    end else if (!md_start) begin
                        if (op_mthi) hi <= src_a;
                        if (op_mtlo) lo <= src_a;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (w_last) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (r_div) begin
                            lo <= w_quo;
                            hi <= w_rem;
                        end else begin
                            hi <= w_prod[2*WIDTH-1:WIDTH];
                            lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_md_sequencer.sv
// Directed checks of md_sequencer: latency, signed/unsigned results, stalls, moves, cancel, reset.
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        md_start = 1'b0;
    logic [1:0]  alu_md = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        op_mthi = 1'b0, op_mtlo = 1'b0, op_mfhi = 1'b0, op_mflo = 1'b0;
    logic        cancel = 1'b0;
    logic        busy, stall, done, div_zero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    int cyc, pulses, n;

    md_sequencer dut (
        .clk(clk), .rst(rst), .md_start(md_start), .alu_md(alu_md),
        .src_a(src_a), .src_b(src_b), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
        .op_mfhi(op_mfhi), .op_mflo(op_mflo), .cancel(cancel),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo),
        .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic start(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        md_start = 1'b1; alu_md = op; src_a = a; src_b = b;
        tick();
        md_start = 1'b0;
    endtask

    // Ticks until done or a 40-cycle budget; returns cycles since acceptance (0 = timeout).
    task automatic wait_done(output int c);
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                c = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        start(op, a, b);
        wait_done(cyc);
        chk({tag, " latency"}, 32'(cyc), 32'd33);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
        tick();
        chk({tag, " done single"}, 32'(done), 32'd0);
    endtask

    initial begin
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset dz", 32'(div_zero), 32'd0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        start(MD_MULT, 32'hFFFF_FFFF, 32'h2);
        chk("mult busy", 32'(busy), 32'd1);
        wait_done(cyc);
        chk("mult latency", 32'(cyc), 32'd33);
        chk("mult hi", hi, 32'hFFFF_FFFF);
        chk("mult lo", lo, 32'hFFFF_FFFE);
        chk("mult busy drop", 32'(busy), 32'd0);
        tick();
        chk("mult done single", 32'(done), 32'd0);

        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 100/-7", MD_DIV, 32'd100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFF2);
        run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu", MD_DIVU, 32'hFFFF_FFF9, 32'h2, 32'h1, 32'h7FFF_FFFC);

        // Divide by zero: pulse only, HI/LO untouched.
        start(MD_DIVU, 32'd7, 32'd0);
        chk("dz pulse", 32'(div_zero), 32'd1);
        chk("dz busy", 32'(busy), 32'd0);
        chk("dz hi", hi, 32'h1);
        chk("dz lo", lo, 32'h7FFF_FFFC);
        tick();
        chk("dz single", 32'(div_zero), 32'd0);

        // Independent instruction flows; mflo in the shadow stalls until the result lands.
        start(MD_MULT, 32'd3, 32'd5);
        #1;
        chk("shadow add stall", 32'(stall), 32'd0);
        tick();
        op_mflo = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall) break;
            n++;
            tick();
        end
        chk("mflo stall cycles", 32'(n), 32'd32);
        chk("mflo reads lo", lo, 32'd15);
        op_mflo = 1'b0;
        tick();

        // Moves in IDLE.
        op_mthi = 1'b1; src_a = 32'h1234_5678;
        tick();
        op_mthi = 1'b0;
        chk("mthi", hi, 32'h1234_5678);
        op_mthi = 1'b1; op_mtlo = 1'b1; src_a = 32'hCAFE_F00D;
        tick();
        op_mthi = 1'b0; op_mtlo = 1'b0;
        chk("mthi+mtlo hi", hi, 32'hCAFE_F00D);
        chk("mthi+mtlo lo", lo, 32'hCAFE_F00D);

        // Start wins over a simultaneous move.
        op_mthi = 1'b1;
        start(MD_MULTU, 32'd6, 32'd7);
        op_mthi = 1'b0;
        chk("start wins hi", hi, 32'hCAFE_F00D);
        wait_done(cyc);
        chk("start wins lo", lo, 32'd42);
        tick();

        // Cancel mid-CALC: no result, HI/LO kept.
        op_mthi = 1'b1; op_mtlo = 1'b1; src_a = 32'hAAAA_5555;
        tick();
        op_mthi = 1'b0; op_mtlo = 1'b0;
        start(MD_MULTU, 32'd9, 32'd9);
        for (int i = 0; i < 5; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("cancel no done", 32'(pulses), 32'd0);
        chk("cancel hi", hi, 32'hAAAA_5555);
        chk("cancel lo", lo, 32'hAAAA_5555);

        // Back-to-back: start held in EX is re-accepted the cycle after done.
        md_start = 1'b1; alu_md = MD_MULTU; src_a = 32'd3; src_b = 32'd4;
        tick();
        chk("b2b first busy", 32'(busy), 32'd1);
        wait_done(cyc);
        chk("b2b first latency", 32'(cyc), 32'd33);
        chk("b2b first lo", lo, 32'd12);
        tick();
        md_start = 1'b0;
        chk("b2b second accepted", 32'(busy), 32'd1);
        wait_done(cyc);
        chk("b2b second latency", 32'(cyc), 32'd33);
        tick();

        // Asynchronous reset mid-CALC.
        start(MD_MULT, 32'd11, 32'd13);
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst hi", hi, 32'h0);
        chk("rst lo", lo, 32'h0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("rst no done", 32'(pulses), 32'd0);
        chk("rst idle busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
